// File: rtl/atmega_pcint.sv
// rtl/atmega_pcint.sv - pin-change interrupt controller for one 8-bit PIO group
//
// Synchronizes the port pins, detects qualifying edges on masked pins, latches
// a pending flag plus a snapshot of the pins, and requests an interrupt.
//
// Ports:
//   rst      async active-high reset
//   clk      rising-edge clock
//   addr     I/O bus address
//   wr, rd   single-cycle write strobe / read strobe
//   bus_in   write data
//   bus_out  combinational read data (0 unless a mapped register is read)
//   io_in    asynchronous pin levels
//   int_req  level interrupt request (PCIE & PCIF)
//   int_ack  one-cycle vector-fetch acknowledge, clears PCIF
`timescale 1ns/1ps
module atmega_pcint #(
  parameter int          BUS_ADDR_IO_LEN = 16,
  parameter int          PCICR_ADDR      = 0,
  parameter int          PCIFR_ADDR      = 1,
  parameter int          PCMSK_ADDR      = 2,
  parameter int          PCEDG_ADDR      = 3,
  parameter int          PCCAP_ADDR      = 4,
  parameter logic [7:0]  PINMASK         = 8'hFF
) (
  input  logic                       rst,
  input  logic                       clk,
  input  logic [BUS_ADDR_IO_LEN-1:0] addr,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [7:0]                 bus_in,
  output logic [7:0]                 bus_out,
  input  logic [7:0]                 io_in,
  output logic                       int_req,
  input  logic                       int_ack
);

  localparam logic [BUS_ADDR_IO_LEN-1:0] L_PCICR = BUS_ADDR_IO_LEN'(PCICR_ADDR);
  localparam logic [BUS_ADDR_IO_LEN-1:0] L_PCIFR = BUS_ADDR_IO_LEN'(PCIFR_ADDR);
  localparam logic [BUS_ADDR_IO_LEN-1:0] L_PCMSK = BUS_ADDR_IO_LEN'(PCMSK_ADDR);
  localparam logic [BUS_ADDR_IO_LEN-1:0] L_PCEDG = BUS_ADDR_IO_LEN'(PCEDG_ADDR);
  localparam logic [BUS_ADDR_IO_LEN-1:0] L_PCCAP = BUS_ADDR_IO_LEN'(PCCAP_ADDR);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t     r_state;
  logic       r_pcie;
  logic [7:0] r_pcmsk;
  logic [7:0] r_pcedg;
  logic [7:0] r_pccap;
  logic [7:0] r_s1;
  logic [7:0] r_s2;
  logic [7:0] r_prev;
  logic [1:0] r_arm_cnt;
  logic       r_armed;

  logic [7:0] w_edge;
  logic       w_hit;
  logic       w_clr;

  // Two-flop synchronizer plus one history stage for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 8'h00;
      r_s2   <= 8'h00;
      r_prev <= 8'h00;
    end else begin
      r_s1   <= io_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // Detection stays off until the pipeline holds real pin samples, so the
  // zero reset contents cannot masquerade as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arm_cnt <= 2'd0;
      r_armed   <= 1'b0;
    end else if (!r_armed) begin
      if (r_arm_cnt == 2'd2) r_armed <= 1'b1;
      else                   r_arm_cnt <= r_arm_cnt + 2'd1;
    end
  end

  assign w_edge = {8{r_armed}} & PINMASK & r_pcmsk & (r_s2 ^ r_prev) & (~r_pcedg | r_s2);
  assign w_hit  = |w_edge;
  assign w_clr  = int_ack | (wr & (addr == L_PCIFR) & bus_in[0]);

  // Configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcie  <= 1'b0;
      r_pcmsk <= 8'h00;
      r_pcedg <= 8'h00;
    end else if (wr) begin
      if (addr == L_PCICR) r_pcie  <= bus_in[0];
      if (addr == L_PCMSK) r_pcmsk <= bus_in & PINMASK;
      if (addr == L_PCEDG) r_pcedg <= bus_in & PINMASK;
    end
  end

  // Flag FSM. A hit beats a simultaneous clear; a hit while already pending
  // keeps the first snapshot unless the same cycle also clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pccap <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_state <= PEND;
            r_pccap <= r_s2 & PINMASK;
          end
        end
        PEND: begin
          if (w_hit && w_clr) r_pccap <= r_s2 & PINMASK;
          else if (w_clr)     r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign int_req = r_pcie & (r_state == PEND);

  always_comb begin
    bus_out = 8'h00;
    if (rd && !rst) begin
      case (addr)
        L_PCICR: bus_out = {7'b0, r_pcie};
        L_PCIFR: bus_out = {7'b0, r_state == PEND};
        L_PCMSK: bus_out = r_pcmsk;
        L_PCEDG: bus_out = r_pcedg;
        L_PCCAP: bus_out = r_pccap;
        default: bus_out = 8'h00;
      endcase
    end
  end

endmodule

// File: doc/atmega_pcint.md
# atmega_pcint

Pin-change interrupt controller for one 8-bit PIO group: the input-direction companion to the port block. It sits on the same ATmega I/O bus as the port and monitors that port's pins. It synchronizes the pins, detects qualifying edges on masked pins, latches a flag and a pin snapshot, and raises an interrupt request to the CPU core's vector logic, which acknowledges it.

## Interface
- BUS_ADDR_IO_LEN, 16, I/O bus address width
- PCICR_ADDR, 0, control register address; bit0 = PCIE (group interrupt enable)
- PCIFR_ADDR, 1, flag register address; bit0 = PCIF (write 1 to clear)
- PCMSK_ADDR, 2, per-pin enable mask register address
- PCEDG_ADDR, 3, per-pin edge select register address; 0 = any change, 1 = rising only
- PCCAP_ADDR, 4, read-only pin snapshot register address
- PINMASK, 8'hFF, implemented pins; unimplemented bits of PCMSK, PCEDG and PCCAP are forced to 0
- rst  input  1  reset, asynchronous, active-high
- clk  input  1  clock, rising-edge
- addr  input  BUS_ADDR_IO_LEN  I/O bus address
- wr  input  1  write strobe, single cycle
- rd  input  1  read strobe
- bus_in  input  8  write data
- bus_out  output  8  read data, combinational
- io_in  input  8  asynchronous pin levels, the same net as the port block's io_in
- int_req  output  1  interrupt request, level
- int_ack  input  1  one-cycle vector-fetch acknowledge

## Operation
- Reset: PCICR, PCIFR, PCMSK, PCEDG and PCCAP are all 0. Sync stages s1/s2, the prev register and armed are 0. int_req is 0 and bus_out is 0.
- Synchronizer: every edge, s1 <= io_in, s2 <= s1 and prev <= s2.
- Arming: a 2-bit counter runs after reset release. armed becomes 1 at the 3rd clk edge and stays 1 until the next reset. While armed = 0, no edge is detected. This prevents spurious flags from the reset values of the pipeline.
- Qualifying edge on pin i requires all of the following: armed = 1, PINMASK[i] = 1, PCMSK[i] = 1, and s2[i] != prev[i]. When PCEDG[i] = 1 it additionally requires s2[i] = 1.
- hit is the OR of the qualifying edges over all pins.
- Flag state machine, states IDLE (PCIF = 0) and PEND (PCIF = 1):
  - IDLE -> PEND on hit. At the same edge, PCCAP <= s2 & PINMASK.
  - PEND -> IDLE on int_ack, or on a write to PCIFR_ADDR with bus_in[0] = 1, provided hit is 0 in the same cycle.
  - When hit coincides with a clear, set wins: PCIF stays 1 and PCCAP updates to the new s2.
  - A hit while in PEND does not update PCCAP. The first event is preserved.
- PCIF is set regardless of PCIE. This allows polling.
- int_req = PCIE & PCIF, registered-equivalent: it depends only on flip-flop outputs.
- Writes:
  - PCICR bit0 is writable. Bits [7:1] are ignored and read 0.
  - PCMSK and PCEDG take bus_in & PINMASK.
  - Writing 0 to PCIFR bit0 has no effect.
  - PCCAP writes are ignored.
  - Writes to unmapped addresses are ignored.
- Reads, combinational: bus_out = 0 unless rd & ~rst & addr matches a register. PCICR and PCIFR read as {7'b0, bit}.
- Changing PCMSK or PCEDG takes effect for detection in the cycle after the write edge.

## Timing
- An io_in change sampled into s1 at edge k reaches s2 at edge k+1.
- hit is asserted during cycle k+1..k+2, and PCIF/PCCAP update at edge k+2.
- int_req rises immediately after edge k+2 (if PCIE = 1). Latency is 3 edges.
- Pulses shorter than one clk period may be missed. A pulse of 3 or more clk periods is always seen.
- int_ack or a W1C write at edge n drops PCIF and int_req after edge n.
- An async rst at any point forces all state, including armed, to reset values immediately. After release, 3 edges pass before detection resumes.
- Writing PCIE = 1 while PCIF = 1 raises int_req after that write edge.

## Test plan
- Reset with io_in = 8'hFF held: release rst -> no PCIF over 10 cycles. PCCAP = 0 and bus_out = 0 on all reads.
- PCMSK = 8'h01, PCICR = 1, PCEDG = 0; toggle io_in[0] 0->1 -> int_req high exactly 3 edges after first sampling, PCIFR reads 8'h01, PCCAP reads 8'h01.
- PCEDG = 8'h01; drive io_in[0] 1->0 -> no flag. Then drive 0->1 -> flag set.
- io_in[1] toggles with PCMSK = 8'h01 -> no flag. Set PCMSK = 8'h02 and toggle again -> flag set.
- Pending flag: int_ack in the same cycle as a new qualifying hit on pin 2 -> PCIF stays 1 and PCCAP shows bit 2. A W1C write of 8'h01 with no hit -> PCIF = 0 and int_req = 0.
- Assert rst while PCIF = 1 -> PCIF, int_req and PCCAP drop to 0 immediately. A pin edge within 2 edges after release is ignored. An edge after arming sets PCIF.
